// File: rtl/dispatch_pkg.sv
// Shared constants for the stream dispatcher: lane-selection policy codes.
package dispatch_pkg;
  localparam int POLICY_FIXED = 0;
  localparam int POLICY_RR    = 1;
endpackage

// File: rtl/find_first.sv
// Returns the data word of the first valid entry, scanning from index 0
// (REVERSE=0) or from N-1 (REVERSE=1).
module find_first #(
  parameter int N       = 4,
  parameter int DATAW   = 8,
  parameter int REVERSE = 0
) (
  input  logic [N*DATAW-1:0] data_i,
  input  logic [N-1:0]       valid_i,
  output logic [DATAW-1:0]   data_o,
  output logic               valid_o
);

  // The last match written wins, so the loop runs opposite to the priority order.
  always_comb begin
    data_o  = '0;
    valid_o = 1'b0;
    if (REVERSE != 0) begin
      for (int i = 0; i < N; i++) begin
        if (valid_i[i]) begin
          data_o  = data_i[i*DATAW +: DATAW];
          valid_o = 1'b1;
        end
      end
    end else begin
      for (int i = N - 1; i >= 0; i--) begin
        if (valid_i[i]) begin
          data_o  = data_i[i*DATAW +: DATAW];
          valid_o = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/stream_dispatch.sv
// Single-input, N-output dispatcher: each accepted beat is registered into one
// free output lane chosen by fixed priority or round-robin.
module stream_dispatch
  import dispatch_pkg::*;
#(
  parameter int N       = 4,
  parameter int DATAW   = 8,
  parameter int REVERSE = 0,
  parameter int POLICY  = POLICY_FIXED,
  localparam int LOGN   = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [DATAW-1:0]   in_data_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  output logic [N*DATAW-1:0] out_data_o,
  output logic [N-1:0]       out_valid_o,
  input  logic [N-1:0]       out_ready_i,
  output logic               grant_valid_o,
  output logic [LOGN-1:0]    grant_idx_o
);

  typedef logic [LOGN-1:0] lane_idx_t;

  localparam logic [LOGN:0] N_EXT  = (LOGN+1)'(N);
  localparam int            FF_REV = (POLICY == POLICY_RR) ? 0 : REVERSE;

  // (a + b) mod N for a, b < N; handles non-power-of-2 N.
  function automatic lane_idx_t wrap_add(input lane_idx_t a, input lane_idx_t b);
    logic [LOGN:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum >= N_EXT) sum = sum - N_EXT;
    return sum[LOGN-1:0];
  endfunction

  logic [N-1:0]      free;
  logic [N-1:0]      search_free;
  logic [N*LOGN-1:0] lane_ids;
  lane_idx_t         found;
  logic              found_valid;
  lane_idx_t         chosen;
  logic              accept;
  logic              grant_valid_reg;
  lane_idx_t         grant_idx_reg;

  assign free = ~out_valid_o | out_ready_i;

  for (genvar gi = 0; gi < N; gi++) begin : g_ids
    assign lane_ids[gi*LOGN +: LOGN] = LOGN'(gi);
  end

  if (POLICY == POLICY_RR) begin : g_rr
    lane_idx_t ptr_reg;

    // Rotate free so position 0 is the lane at ptr, then map the hit back.
    for (genvar gi = 0; gi < N; gi++) begin : g_rot
      assign search_free[gi] = free[wrap_add(ptr_reg, LOGN'(gi))];
    end
    assign chosen = wrap_add(ptr_reg, found);

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        ptr_reg <= '0;
      end else if (accept) begin
        ptr_reg <= wrap_add(chosen, LOGN'(1));
      end
    end
  end else begin : g_fixed
    assign search_free = free;
    assign chosen      = found;
  end

  find_first #(
    .N      (N),
    .DATAW  (LOGN),
    .REVERSE(FF_REV)
  ) u_find_first (
    .data_i (lane_ids),
    .valid_i(search_free),
    .data_o (found),
    .valid_o(found_valid)
  );

  // found_valid is exactly |free, so it doubles as the input ready.
  assign in_ready_o = found_valid;
  assign accept     = in_valid_i & found_valid;

  for (genvar gi = 0; gi < N; gi++) begin : g_lane
    logic             valid_reg;
    logic [DATAW-1:0] data_reg;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        valid_reg <= 1'b0;
        data_reg  <= '0;
      end else if (accept && (chosen == LOGN'(gi))) begin
        valid_reg <= 1'b1;
        data_reg  <= in_data_i;
      end else if (valid_reg && out_ready_i[gi]) begin
        valid_reg <= 1'b0;
      end
    end

    assign out_valid_o[gi]                 = valid_reg;
    assign out_data_o[gi*DATAW +: DATAW]   = data_reg;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_valid_reg <= 1'b0;
      grant_idx_reg   <= '0;
    end else begin
      grant_valid_reg <= accept;
      if (accept) grant_idx_reg <= chosen;
    end
  end

  assign grant_valid_o = grant_valid_reg;
  assign grant_idx_o   = grant_idx_reg;

endmodule

// File: tb/tb_stream_dispatch.sv
// Scoreboarded bench for stream_dispatch: four configurations driven in
// parallel (fixed, fixed-reverse, round-robin N=4, round-robin N=3).
module tb_stream_dispatch;

  typedef struct {
    int         lane;
    logic [7:0] data;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] stim_valid;
  logic [7:0] stim_data [4];
  logic [3:0] stim_ready [4];

  logic [3:0] obs_valid [4];
  logic [7:0] obs_data [4][4];
  logic       obs_ir [4];
  logic       obs_gv [4];
  logic [1:0] obs_gi [4];

  logic [3:0] mv [4];
  logic [7:0] md [4][4];
  int         mptr [4];
  exp_t       expq [4][$];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 4; gi++) begin : g_dut
    localparam int NN = (gi == 3) ? 3 : 4;
    localparam int PP = (gi >= 2) ? 1 : 0;
    localparam int RV = (gi == 1) ? 1 : 0;
    logic [NN*8-1:0] od;
    logic [NN-1:0]   ov;
    logic            ir;
    logic            gv;
    logic [1:0]      gix;

    stream_dispatch #(.N(NN), .DATAW(8), .REVERSE(RV), .POLICY(PP)) u_dut (
      .clk          (clk),
      .rst          (rst),
      .in_data_i    (stim_data[gi]),
      .in_valid_i   (stim_valid[gi]),
      .in_ready_o   (ir),
      .out_data_o   (od),
      .out_valid_o  (ov),
      .out_ready_i  (stim_ready[gi][NN-1:0]),
      .grant_valid_o(gv),
      .grant_idx_o  (gix)
    );

    assign obs_valid[gi] = 4'(ov);
    assign obs_ir[gi]    = ir;
    assign obs_gv[gi]    = gv;
    assign obs_gi[gi]    = gix;
    for (genvar li = 0; li < 4; li++) begin : g_obs
      if (li < NN) begin : g_real
        assign obs_data[gi][li] = od[li*8 +: 8];
      end else begin : g_none
        assign obs_data[gi][li] = 8'h00;
      end
    end
  end

  function automatic int cfg_n(int d);
    return (d == 3) ? 3 : 4;
  endfunction
  function automatic bit cfg_rr(int d);
    return d >= 2;
  endfunction
  function automatic bit cfg_rev(int d);
    return d == 1;
  endfunction

  // Lane choice straight from the selection rules, with plain modular arithmetic.
  function automatic int ref_choose(int d, logic [3:0] fr);
    int n = cfg_n(d);
    if (cfg_rr(d)) begin
      for (int k = 0; k < n; k++)
        if (fr[(mptr[d] + k) % n]) return (mptr[d] + k) % n;
    end else if (cfg_rev(d)) begin
      for (int l = n - 1; l >= 0; l--)
        if (fr[l]) return l;
    end else begin
      for (int l = 0; l < n; l++)
        if (fr[l]) return l;
    end
    return -1;
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int d = 0; d < 4; d++) begin
      mv[d]   = '0;
      mptr[d] = 0;
      for (int l = 0; l < 4; l++) md[d][l] = 8'h00;
    end
  endtask

  // Asserts reset away from any clock edge and checks it clears outputs at once.
  task automatic do_reset();
    #2;
    rst = 1'b1;
    #1;
    for (int d = 0; d < 4; d++) begin
      chk($sformatf("rst_valid d%0d", d), int'(obs_valid[d]), 0);
      chk($sformatf("rst_grant d%0d", d), int'(obs_gv[d]), 0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();
  endtask

  // One clock: predict from the model, then compare lane state after the edge.
  task automatic do_cycle();
    #1;
    for (int d = 0; d < 4; d++) begin
      int         n = cfg_n(d);
      logic [3:0] fr;
      int         ch;
      exp_t       e;
      fr = '0;
      for (int l = 0; l < n; l++) fr[l] = !mv[d][l] || stim_ready[d][l];
      chk($sformatf("in_ready d%0d", d), int'(obs_ir[d]), int'(fr != 0));
      ch = -1;
      if (stim_valid[d] && fr != 0) begin
        ch     = ref_choose(d, fr);
        e.lane = ch;
        e.data = stim_data[d];
        expq[d].push_back(e);
        if (cfg_rr(d)) mptr[d] = (ch + 1) % n;
      end
      for (int l = 0; l < n; l++) begin
        if (l == ch) begin
          mv[d][l] = 1'b1;
          md[d][l] = stim_data[d];
        end else if (mv[d][l] && stim_ready[d][l]) begin
          mv[d][l] = 1'b0;
        end
      end
    end
    @(posedge clk);
    #1;
    for (int d = 0; d < 4; d++) begin
      chk($sformatf("out_valid d%0d", d), int'(obs_valid[d]), int'(mv[d]));
      for (int l = 0; l < 4; l++)
        if (mv[d][l]) chk($sformatf("lane_data d%0d l%0d", d, l), int'(obs_data[d][l]), int'(md[d][l]));
    end
  endtask

  task automatic set_all(logic v, logic [7:0] data, logic [3:0] rdy);
    stim_valid = {4{v}};
    for (int d = 0; d < 4; d++) begin
      stim_data[d]  = data;
      stim_ready[d] = rdy;
    end
  endtask

  task automatic check_drained();
    #2;
    for (int d = 0; d < 4; d++)
      chk($sformatf("pending_grants d%0d", d), expq[d].size(), 0);
  endtask

  // Monitor: every grant pulse must match the oldest predicted dispatch.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      for (int d = 0; d < 4; d++) begin
        if (obs_gv[d]) begin
          if (expq[d].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL grant_pulse d%0d: got pulse, expected none", d);
          end else begin
            e = expq[d].pop_front();
            chk($sformatf("grant_idx d%0d", d), int'(obs_gi[d]), e.lane);
            chk($sformatf("grant_data d%0d", d), int'(obs_data[d][e.lane]), int'(e.data));
          end
        end
      end
    end
  end

  initial begin
    model_clear();
    set_all(1'b1, 8'h5A, 4'h0);

    // Reset with valid held, then first beat A5.
    do_reset();
    set_all(1'b1, 8'hA5, 4'h0);
    do_cycle();
    chk("first_beat_idx", int'(obs_gi[0]), 0);
    chk("first_beat_data", int'(obs_data[0][0]), 8'hA5);
    check_drained();

    // Fill all lanes, stall the fifth beat, then drain lane 2 while reloading it.
    do_reset();
    for (int b = 1; b <= 5; b++) begin
      set_all(1'b1, 8'(b), 4'h0);
      do_cycle();
    end
    chk("full_valid", int'(obs_valid[0]), 4'hF);
    set_all(1'b1, 8'h05, 4'b0100);
    do_cycle();
    chk("reload_lane2", int'(obs_data[0][2]), 8'h05);
    chk("reload_nobubble", int'(obs_valid[0]), 4'hF);
    check_drained();

    // Reverse priority picks the top lane.
    do_reset();
    set_all(1'b1, 8'h3C, 4'h0);
    do_cycle();
    chk("reverse_idx", int'(obs_gi[1]), 3);
    check_drained();

    // Round-robin with every lane ready.
    do_reset();
    for (int c = 0; c < 8; c++) begin
      set_all(1'b1, 8'($urandom_range(0, 255)), 4'hF);
      do_cycle();
      chk("rr_seq", int'(obs_gi[2]), c % 4);
    end
    check_drained();

    // Lane 1 stuck full, lanes 0 and 2 drain every cycle.
    do_reset();
    for (int c = 0; c < 6; c++) begin
      set_all(1'b1, 8'($urandom_range(0, 255)), 4'b0101);
      do_cycle();
    end
    check_drained();

    // Leave lanes 0 and 2 occupied, then reset mid-cycle.
    do_reset();
    for (int c = 0; c < 3; c++) begin
      set_all(1'b1, 8'(8'h10 + c), 4'h0);
      do_cycle();
    end
    set_all(1'b0, 8'h00, 4'b0010);
    do_cycle();
    chk("pre_reset_valid", int'(obs_valid[0]), 4'b0101);
    check_drained();
    do_reset();
    set_all(1'b1, 8'h77, 4'h0);
    do_cycle();
    chk("post_reset_idx", int'(obs_gi[0]), 0);
    chk("post_reset_rr_idx", int'(obs_gi[2]), 0);
    check_drained();

    // Randomised traffic on all four configurations.
    do_reset();
    for (int c = 0; c < 400; c++) begin
      stim_valid = 4'($urandom_range(0, 15)) | 4'($urandom_range(0, 15));
      for (int d = 0; d < 4; d++) begin
        stim_data[d]  = 8'($urandom_range(0, 255));
        stim_ready[d] = 4'($urandom_range(0, 15));
      end
      do_cycle();
    end
    set_all(1'b0, 8'h00, 4'h0);
    check_drained();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
